// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and op decode helpers for the EX-stage RV32M multiply/divide unit.
package ex_muldiv_unit_pkg;

    localparam int unsigned MD_XLEN  = 32;
    localparam int unsigned MD_ITER  = 32;
    localparam int unsigned MD_CNT_W = 5;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } MulDivOp_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } MulDivState_t;

    function automatic logic md_is_mul(input MulDivOp_t op);
        return ~op[2];
    endfunction

    function automatic logic md_is_rem(input MulDivOp_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic md_mul_hi(input MulDivOp_t op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
    endfunction

    // Rs1 is two's complement for MULH, MULHSU, DIV and REM
    function automatic logic md_signed_a(input MulDivOp_t op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // Rs2 is two's complement for MULH, DIV and REM
    function automatic logic md_signed_b(input MulDivOp_t op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Two-lane sign fixer: takes magnitudes of signed inputs, or conditionally negates results.
module muldiv_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         tc_a,
    input  logic         tc_b,
    input  logic         inv_a,
    input  logic         inv_b,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic         neg_a,
    output logic         neg_b
);

    // A lane is negated when it is a negative signed value, or when an explicit invert is asked for
    always_comb begin
        neg_a = tc_a & in_a[W-1];
        neg_b = tc_b & in_b[W-1];
        out_a = (neg_a ^ inv_a) ? (~in_a + W'(1)) : in_a;
        out_b = (neg_b ^ inv_b) ? (~in_b + W'(1)) : in_b;
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage (shift-add MUL, restoring DIV/REM).
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiplier for the MUL group.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = MD_XLEN
) (
    input  logic            clk_IDEX,
    input  logic            rst_IDEX,
    input  logic            flush_EX,
    input  logic            start_EX,
    input  logic [2:0]      op_EX,
    input  logic [XLEN-1:0] Rs1_EX,
    input  logic [XLEN-1:0] Rs2_EX,
    input  logic [4:0]      Rd_addr_EX,
    output logic            busy_EX,
    output logic            stall_req_EX,
    output logic            done_EX,
    output logic [XLEN-1:0] result_EX,
    output logic [4:0]      Rd_addr_out_EX
);

    localparam int unsigned AW = 2 * XLEN;

    MulDivState_t        state_q;
    MulDivOp_t           op_q;
    logic [MD_CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]     opnd_q;
    logic [AW-1:0]       acc_q;
    logic                neg_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;
    logic [4:0]          rd_q;

    MulDivOp_t       op_in;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            sgn_a;
    logic            sgn_b;
    logic            neg_pre;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_trial;
    logic [AW-1:0]   acc_next;
    logic [AW-1:0]   post_acc;
    MulDivOp_t       post_op;
    logic            post_neg;
    logic [AW-1:0]   post_q_in;
    logic [AW-1:0]   post_r_in;
    logic [AW-1:0]   post_a;
    logic [AW-1:0]   post_b;
    logic            post_neg_a_unused;
    logic            post_neg_b_unused;
    logic            md_unused;
    logic [XLEN-1:0] post_res;

    assign op_in = MulDivOp_t'(op_EX);

    // Operand magnitudes and sign flags taken straight from ID/EX
    muldiv_signfix #(.W(XLEN)) u_pre (
        .in_a  (Rs1_EX),
        .in_b  (Rs2_EX),
        .tc_a  (md_signed_a(op_in)),
        .tc_b  (md_signed_b(op_in)),
        .inv_a (1'b0),
        .inv_b (1'b0),
        .out_a (abs_a),
        .out_b (abs_b),
        .neg_a (sgn_a),
        .neg_b (sgn_b)
    );

    // Divide-by-zero / signed-overflow short cuts and the result sign to apply later
    always_comb begin
        div_zero = ~md_is_mul(op_in) & (Rs2_EX == '0);
        div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM))
                   && (Rs1_EX == {1'b1, {(XLEN-1){1'b0}}}) && (Rs2_EX == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_res = md_is_rem(op_in) ? Rs1_EX : '1;
        end else begin
            special_res = md_is_rem(op_in) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
        neg_pre = md_is_rem(op_in) ? sgn_a : (sgn_a ^ sgn_b);
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = acc_q[AW-1:XLEN-1] - {1'b0, opnd_q};
        if (md_is_mul(op_q)) begin
            acc_next = {mul_sum, acc_q[XLEN-1:1]};
        end else if (!div_trial[XLEN]) begin
            acc_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {acc_q[AW-2:0], 1'b0};
        end
    end

    // Source of the raw unsigned result fed to the sign correction
    always_comb begin
        post_acc = acc_next;
        post_op  = op_q;
        post_neg = neg_q;
`ifdef MULDIV_FAST_MUL_EN
        if (state_q == MD_IDLE) begin
            post_acc = AW'(abs_a) * AW'(abs_b);
            post_op  = op_in;
            post_neg = neg_pre;
        end
`endif
        post_q_in = md_is_mul(post_op) ? post_acc : AW'(post_acc[XLEN-1:0]);
        post_r_in = AW'(post_acc[AW-1:XLEN]);
    end

    // Final negation of product/quotient (lane a) and remainder (lane b)
    muldiv_signfix #(.W(AW)) u_post (
        .in_a  (post_q_in),
        .in_b  (post_r_in),
        .tc_a  (1'b0),
        .tc_b  (1'b0),
        .inv_a (post_neg),
        .inv_b (post_neg),
        .out_a (post_a),
        .out_b (post_b),
        .neg_a (post_neg_a_unused),
        .neg_b (post_neg_b_unused)
    );

    assign md_unused = ^{post_b[AW-1:XLEN], post_neg_a_unused, post_neg_b_unused};

    // Pick the result word for the op
    always_comb begin
        if (md_is_rem(post_op)) begin
            post_res = post_b[XLEN-1:0];
        end else if (md_mul_hi(post_op)) begin
            post_res = post_a[AW-1:XLEN];
        end else begin
            post_res = post_a[XLEN-1:0];
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
        if (rst_IDEX) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_MUL;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush_EX) begin
                state_q <= MD_IDLE;
            end else begin
                case (state_q)
                    MD_IDLE: begin
                        if (start_EX) begin
                            op_q   <= op_in;
                            rd_q   <= Rd_addr_EX;
                            neg_q  <= neg_pre;
                            cnt_q  <= MD_CNT_W'(MD_ITER - 1);
                            opnd_q <= md_is_mul(op_in) ? abs_a : abs_b;
                            acc_q  <= {{XLEN{1'b0}}, (md_is_mul(op_in) ? abs_b : abs_a)};
                            if (special) begin
                                result_q <= special_res;
                                done_q   <= 1'b1;
                                state_q  <= MD_DONE;
                            end
`ifdef MULDIV_FAST_MUL_EN
                            else if (md_is_mul(op_in)) begin
                                result_q <= post_res;
                                done_q   <= 1'b1;
                                state_q  <= MD_DONE;
                            end
`endif
                            else begin
                                state_q <= MD_CALC;
                            end
                        end
                    end
                    MD_CALC: begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q - MD_CNT_W'(1);
                        if (cnt_q == '0) begin
                            result_q <= post_res;
                            done_q   <= 1'b1;
                            state_q  <= MD_DONE;
                        end
                    end
                    MD_DONE: state_q <= MD_IDLE;
                    default: state_q <= MD_IDLE;
                endcase
            end
        end
    end

    assign busy_EX        = (state_q != MD_IDLE);
    assign stall_req_EX   = ((state_q == MD_IDLE) && start_EX && !flush_EX) || (state_q == MD_CALC);
    assign done_EX        = done_q;
    assign result_EX      = result_q;
    assign Rd_addr_out_EX = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with a result/destination scoreboard.
// Honours MULDIV_FAST_MUL_EN for the expected MUL-group latency.
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int          LM       = 1;
    localparam logic [2:0]  FLUSH_OP = 3'b101;
`else
    localparam int          LM       = 33;
    localparam logic [2:0]  FLUSH_OP = 3'b000;
`endif

    logic        clk_IDEX;
    logic        rst_IDEX;
    logic        flush_EX;
    logic        start_EX;
    logic [2:0]  op_EX;
    logic [31:0] Rs1_EX;
    logic [31:0] Rs2_EX;
    logic [4:0]  Rd_addr_EX;
    logic        busy_EX;
    logic        stall_req_EX;
    logic        done_EX;
    logic [31:0] result_EX;
    logic [4:0]  Rd_addr_out_EX;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] last_res;

    ex_muldiv_unit dut (
        .clk_IDEX       (clk_IDEX),
        .rst_IDEX       (rst_IDEX),
        .flush_EX       (flush_EX),
        .start_EX       (start_EX),
        .op_EX          (op_EX),
        .Rs1_EX         (Rs1_EX),
        .Rs2_EX         (Rs2_EX),
        .Rd_addr_EX     (Rd_addr_EX),
        .busy_EX        (busy_EX),
        .stall_req_EX   (stall_req_EX),
        .done_EX        (done_EX),
        .result_EX      (result_EX),
        .Rd_addr_out_EX (Rd_addr_out_EX)
    );

    initial begin
        clk_IDEX = 1'b0;
        forever #5 clk_IDEX = ~clk_IDEX;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_IDEX);
        #1;
    endtask

    // Reference RV32M semantics
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ps, psu;
        logic [63:0] pu;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ps  = sa * sb;
        psu = sa * longint'({32'b0, b});
        pu  = {32'b0, a} * {32'b0, b};
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b000:  return ps[31:0];
            3'b001:  return ps[63:32];
            3'b010:  return psu[63:32];
            3'b011:  return pu[63:32];
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : (a / b);
            3'b110:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
            default: return (b == 0) ? a : (a % b);
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return LM;
        if (b == 0) return 1;
        if (((op == 3'b100) || (op == 3'b110)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Issue one instruction, hold it in ID/EX until done, then score it
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int lat);
        exp_t e;
        int   cyc;
        logic stall_ok;
        e.res = exp_res; e.rd = rd; e.lat = lat; e.tag = tag;
        sb_q.push_back(e);
        op_EX = op; Rs1_EX = a; Rs2_EX = b; Rd_addr_EX = rd; start_EX = 1'b1;
        #1;
        cyc = 0;
        stall_ok = 1'b1;
        while (done_EX !== 1'b1 && cyc < 40) begin
            if (stall_req_EX !== 1'b1) stall_ok = 1'b0;
            tick();
            cyc++;
        end
        e = sb_q.pop_front();
        check({e.tag, "_stall"}, 32'(stall_ok), 32'd1);
        check({e.tag, "_latency"}, 32'(cyc), 32'(e.lat));
        check({e.tag, "_result"}, result_EX, e.res);
        check({e.tag, "_rd"}, 32'(Rd_addr_out_EX), 32'(e.rd));
        check({e.tag, "_stall_in_done"}, 32'(stall_req_EX), 32'd0);
        tick();
        start_EX = 1'b0;
        #1;
        check({e.tag, "_done_one_cycle"}, 32'(done_EX), 32'd0);
        check({e.tag, "_result_hold"}, result_EX, e.res);
        last_res = e.res;
    endtask

    initial begin
        logic        done_seen;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_IDEX = 1'b1; flush_EX = 1'b0; start_EX = 1'b0;
        op_EX = 3'b000; Rs1_EX = '0; Rs2_EX = '0; Rd_addr_EX = '0;
        last_res = '0;
        #3;
        check("rst_busy", 32'(busy_EX), 32'd0);
        check("rst_stall", 32'(stall_req_EX), 32'd0);
        check("rst_done", 32'(done_EX), 32'd0);
        check("rst_result", result_EX, 32'd0);
        check("rst_rd", 32'(Rd_addr_out_EX), 32'd0);
        @(negedge clk_IDEX);
        rst_IDEX = 1'b0;
        tick();

        issue("mul_7x6",      3'b000, 32'd7,          32'd6, 5'd5,  32'd42,          LM);
        issue("mulh_m2x3",    3'b001, 32'hFFFF_FFFE,  32'd3, 5'd6,  32'hFFFF_FFFF,   LM);
        issue("mulhu_m2x3",   3'b011, 32'hFFFF_FFFE,  32'd3, 5'd7,  32'h0000_0002,   LM);
        issue("mulhsu_m2x3",  3'b010, 32'hFFFF_FFFE,  32'd3, 5'd8,  32'hFFFF_FFFF,   LM);
        issue("mulhsu_2xmax", 3'b010, 32'd2, 32'hFFFF_FFFF, 5'd9,   32'h0000_0001,   LM);
        issue("div_by_zero",  3'b100, 32'd100,        32'd0, 5'd10, 32'hFFFF_FFFF,   1);
        issue("remu_by_zero", 3'b111, 32'd100,        32'd0, 5'd11, 32'd100,         1);
        issue("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        issue("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0,    1);
        issue("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2, 5'd14, 32'hFFFF_FFFD,   33);
        issue("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2, 5'd15, 32'hFFFF_FFFF,   33);
        issue("divu_big_2",   3'b101, 32'hFFFF_FFF9,  32'd2, 5'd16, 32'h7FFF_FFFC,   33);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            issue("rand", rop, ra, rb, 5'(i + 17), model(rop, ra, rb), exp_lat(rop, ra, rb));
        end

        // Flush mid-operation: no done, result untouched, pipeline released
        op_EX = FLUSH_OP; Rs1_EX = 32'd3; Rs2_EX = 32'd5; Rd_addr_EX = 5'd30; start_EX = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            done_seen = done_seen | done_EX;
        end
        flush_EX = 1'b1;
        tick();
        flush_EX = 1'b0;
        start_EX = 1'b0;
        #1;
        done_seen = done_seen | done_EX;
        check("flush_stall", 32'(stall_req_EX), 32'd0);
        check("flush_busy", 32'(busy_EX), 32'd0);
        check("flush_no_done", 32'(done_seen), 32'd0);
        check("flush_result_kept", result_EX, last_res);
        tick();
        issue("after_flush", 3'b000, 32'd9, 32'd11, 5'd3, 32'd99, LM);

        // Asynchronous reset between edges while iterating
        op_EX = 3'b101; Rs1_EX = 32'd1000; Rs2_EX = 32'd7; Rd_addr_EX = 5'd21; start_EX = 1'b1;
        for (int c = 0; c < 15; c++) tick();
        #2;
        rst_IDEX = 1'b1;
        start_EX = 1'b0;
        #1;
        check("arst_busy", 32'(busy_EX), 32'd0);
        check("arst_stall", 32'(stall_req_EX), 32'd0);
        check("arst_done", 32'(done_EX), 32'd0);
        check("arst_result", result_EX, 32'd0);
        check("arst_rd", 32'(Rd_addr_out_EX), 32'd0);
        #1;
        rst_IDEX = 1'b0;
        last_res = '0;
        tick();
        issue("after_reset", 3'b000, 32'd7, 32'd6, 5'd4, 32'd42, LM);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
